// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared definitions for the unified-memory arbiter between the instruction
// fetch port (I) and the load/store port (D).
//
// Contents:
//   owner_e        - encoding of which port owns an access (OWN_I / OWN_D)
//   WREN_NONE      - byte-enable pattern for a read (no lanes written)
//   WREN_WORD      - byte-enable pattern for a full-word store
//   STARVE_W       - width of the I-port starvation counter
//   grant_owner()  - maps the D grant bit onto an owner encoding
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    localparam logic [3:0] WREN_NONE = 4'b0000;
    localparam logic [3:0] WREN_WORD = 4'b1111;

    localparam int STARVE_W = 4;

    // Only two owners exist, so the D grant alone decides who owns the access.
    function automatic owner_e grant_owner(input logic d_gnt);
        return d_gnt ? OWN_D : OWN_I;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// -----------------------------------------------------------------------------
// mem_arb_pick
// Purely combinational grant picker for the two memory requesters.
//
// Ports:
//   i_vld   in   fetch port requests this cycle
//   d_vld   in   load/store port requests this cycle
//   i_prio  in   1 = I wins a contention, 0 = D wins a contention
//   i_gnt   out  fetch port granted (one-hot with d_gnt)
//   d_gnt   out  load/store port granted (one-hot with i_gnt)
// -----------------------------------------------------------------------------
module mem_arb_pick (
    input  logic i_vld,
    input  logic d_vld,
    input  logic i_prio,
    output logic i_gnt,
    output logic d_gnt
);

    // A lone requester always wins; the priority bit only matters when both
    // ports ask in the same cycle. The two expressions are mutually exclusive
    // by construction, so the grant is always one-hot or zero.
    always_comb begin
        i_gnt = i_vld & (~d_vld | i_prio);
        d_gnt = d_vld & ~(i_vld & i_prio);
    end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one single-port, 1-cycle-latency memory between the instruction
// fetch port (I, read-only) and the load/store port (D, read/write with byte
// enables). At most one request is granted per cycle; the response is routed
// back to its owner one cycle after the grant.
//
// Build option:
//   MEM_ARB_RR_EN  defined   -> strict round-robin between I and D
//                  undefined -> D priority with an I starvation guard
//
// Parameters:
//   AW          byte-address width of both ports and the memory
//   STARVE_MAX  consecutive lost I cycles before I beats D (legal 1..15)
//
// Ports:
//   clk           in   core clock
//   rst           in   synchronous active-low reset
//   i_req_vld     in   fetch request
//   i_req_addr    in   fetch address (word aligned)
//   i_req_rdy     out  fetch granted this cycle
//   i_rsp_vld     out  fetch data valid
//   i_rsp_rdata   out  fetched instruction
//   d_req_vld     in   data request
//   d_req_addr    in   data address
//   d_req_wren    in   byte write enables, 0 = read
//   d_req_wrdata  in   lane-aligned store data
//   d_req_rdy     out  data request granted this cycle
//   d_rsp_vld     out  load data valid or store acknowledge
//   d_rsp_rdata   out  raw memory word
//   mem_en        out  memory access strobe
//   mem_we        out  memory byte write enables
//   mem_addr      out  memory address
//   mem_wdata     out  memory write data
//   mem_rdata     in   memory read data, valid one cycle after mem_en
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          i_req_vld,
    input  logic [AW-1:0] i_req_addr,
    output logic          i_req_rdy,
    output logic          i_rsp_vld,
    output logic [31:0]   i_rsp_rdata,

    input  logic          d_req_vld,
    input  logic [AW-1:0] d_req_addr,
    input  logic [3:0]    d_req_wren,
    input  logic [31:0]   d_req_wrdata,
    output logic          d_req_rdy,
    output logic          d_rsp_vld,
    output logic [31:0]   d_rsp_rdata,

    output logic          mem_en,
    output logic [3:0]    mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    logic   i_gnt;
    logic   d_gnt;
    logic   any_gnt;
    logic   i_prio;
    logic   pend_q;
    owner_e own_q;

    // Requests are masked while reset is held so that no grant, memory strobe
    // or ready can escape during the reset cycle itself.
    logic i_vld_live;
    logic d_vld_live;

    assign i_vld_live = i_req_vld & rst;
    assign d_vld_live = d_req_vld & rst;

`ifdef MEM_ARB_RR_EN
    // Round-robin: the port that did not win last time gets the contention.
    owner_e last_q;

    assign i_prio = (last_q == OWN_D);
`else
    // D priority, except once I has lost STARVE_MAX cycles in a row.
    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    logic [STARVE_W-1:0] starve_cnt;

    assign i_prio = (starve_cnt == STARVE_LIM);
`endif

    mem_arb_pick u_pick (
        .i_vld  (i_vld_live),
        .d_vld  (d_vld_live),
        .i_prio (i_prio),
        .i_gnt  (i_gnt),
        .d_gnt  (d_gnt)
    );

    assign any_gnt = i_gnt | d_gnt;

    assign i_req_rdy = i_gnt;
    assign d_req_rdy = d_gnt;

    // Memory command mux. An I access is always a read, and with no grant the
    // bus is driven to zero so idle cycles are easy to spot on a trace.
    always_comb begin
        mem_en    = any_gnt;
        mem_we    = WREN_NONE;
        mem_addr  = '0;
        mem_wdata = '0;
        if (d_gnt) begin
            mem_we    = d_req_wren;
            mem_addr  = d_req_addr;
            mem_wdata = d_req_wrdata;
        end else if (i_gnt) begin
            mem_addr  = i_req_addr;
        end
    end

    // Response tracking: pend_q marks that last cycle issued an access and
    // own_q remembers whose it was. pend_q drops on any idle cycle so a stale
    // owner can never produce a response.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pend_q <= 1'b0;
            own_q  <= OWN_I;
        end else begin
            pend_q <= any_gnt;
            if (any_gnt) begin
                own_q <= grant_owner(d_gnt);
            end
        end
    end

`ifdef MEM_ARB_RR_EN
    // last_q starts at D so that I takes the first contention after reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_q <= OWN_D;
        end else if (any_gnt) begin
            last_q <= grant_owner(d_gnt);
        end
    end
`else
    // The counter saturates rather than wrapping, so I keeps priority for as
    // long as it stays blocked; any I grant or withdrawn I request clears it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (i_req_vld && !i_gnt) begin
            if (starve_cnt != STARVE_LIM) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end else begin
            starve_cnt <= '0;
        end
    end
`endif

    // Responses are qualified by rst as well as pend_q: an access granted the
    // cycle before reset must not report a response during reset.
    always_comb begin
        i_rsp_vld   = rst & pend_q & (own_q == OWN_I);
        d_rsp_vld   = rst & pend_q & (own_q == OWN_D);
        i_rsp_rdata = i_rsp_vld ? mem_rdata : 32'h0;
        d_rsp_rdata = d_rsp_vld ? mem_rdata : 32'h0;
    end

endmodule
